// File: rtl/debounced_updown_counter_if.sv
// Button/LED bundle between the board-level driver and the debounced up/down counter.
// The master drives the raw active-low buttons; the slave returns the count and step pulses.
interface debounced_updown_counter_if #(
    parameter int WIDTH = 8
);
    logic [2:0]       btn_n;
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] led_n;
    logic             step_up;
    logic             step_down;
    logic             wrapped;

    modport master (output btn_n, input count, led_n, step_up, step_down, wrapped);
    modport slave  (input btn_n, output count, led_n, step_up, step_down, wrapped);
endinterface

// File: rtl/debounced_updown_counter.sv
// WIDTH-bit up/down counter fed by three raw active-low buttons (clear, up, down).
// Each button is synchronised, debounced and optionally auto-repeated on the tick clock.
module debounced_updown_counter_btn #(
    parameter int TW             = 5,
    parameter int DEBOUNCE_TICKS = 4,
    parameter int REPEAT_DELAY   = 16,
    parameter int REPEAT_RATE    = 4,
    parameter bit CAN_REPEAT     = 1'b1
) (
    input  logic clock_divider_out,
    input  logic reset,
    input  logic i_btn_n,
    output logic o_step
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_DEB_PRESS,
        S_HELD,
        S_REPEAT,
        S_DEB_REL
    } state_t;

    localparam logic [TW-1:0] DEB_LAST  = TW'(DEBOUNCE_TICKS - 1);
    localparam logic [TW-1:0] DLY_LAST  = TW'(REPEAT_DELAY - 1);
    localparam logic [TW-1:0] RATE_LAST = TW'(REPEAT_RATE - 1);

    state_t        r_state, w_state_nxt;
    logic [TW-1:0] r_t, w_t_nxt;
    logic          r_sync1, r_p;
    logic          r_step, w_step_nxt;

    always_ff @(posedge clock_divider_out or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_p     <= 1'b0;
            r_state <= S_IDLE;
            r_t     <= '0;
            r_step  <= 1'b0;
        end else begin
            r_sync1 <= ~i_btn_n;
            r_p     <= r_sync1;
            r_state <= w_state_nxt;
            r_t     <= w_t_nxt;
            r_step  <= w_step_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_t_nxt     = r_t;
        w_step_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_p) begin
                    w_state_nxt = S_DEB_PRESS;
                    w_t_nxt     = '0;
                end
            end
            S_DEB_PRESS: begin
                if (!r_p) begin
                    w_state_nxt = S_IDLE;
                    w_t_nxt     = '0;
                end else if (r_t == DEB_LAST) begin
                    w_state_nxt = S_HELD;
                    w_t_nxt     = '0;
                    w_step_nxt  = 1'b1;
                end else begin
                    w_t_nxt = r_t + 1'b1;
                end
            end
            S_HELD: begin
                if (!r_p) begin
                    w_state_nxt = S_DEB_REL;
                    w_t_nxt     = '0;
                end else if (CAN_REPEAT) begin
                    if (r_t == DLY_LAST) begin
                        w_state_nxt = S_REPEAT;
                        w_t_nxt     = '0;
                        w_step_nxt  = 1'b1;
                    end else begin
                        w_t_nxt = r_t + 1'b1;
                    end
                end
            end
            S_REPEAT: begin
                if (!r_p) begin
                    w_state_nxt = S_DEB_REL;
                    w_t_nxt     = '0;
                end else if (r_t == RATE_LAST) begin
                    w_t_nxt    = '0;
                    w_step_nxt = 1'b1;
                end else begin
                    w_t_nxt = r_t + 1'b1;
                end
            end
            S_DEB_REL: begin
                // A press seen while releasing is bounce: back to HELD, repeat delay restarts.
                if (r_p) begin
                    w_state_nxt = S_HELD;
                    w_t_nxt     = '0;
                end else if (r_t == DEB_LAST) begin
                    w_state_nxt = S_IDLE;
                    w_t_nxt     = '0;
                end else begin
                    w_t_nxt = r_t + 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_t_nxt     = '0;
            end
        endcase
    end

    assign o_step = r_step;
endmodule

module debounced_updown_counter #(
    parameter int WIDTH          = 8,
    parameter int DEBOUNCE_TICKS = 4,
    parameter int REPEAT_EN      = 1,
    parameter int REPEAT_DELAY   = 16,
    parameter int REPEAT_RATE    = 4,
    parameter int SATURATE       = 0
) (
    input logic                       clock_divider_out,
    input logic                       reset,
    debounced_updown_counter_if.slave bus
);
    localparam int MAXT0 = (DEBOUNCE_TICKS > REPEAT_DELAY) ? DEBOUNCE_TICKS : REPEAT_DELAY;
    localparam int MAXT  = (MAXT0 > REPEAT_RATE) ? MAXT0 : REPEAT_RATE;
    localparam int TW    = $clog2(MAXT) + 1;

    logic [2:0]       w_step;
    logic [WIDTH-1:0] r_count, w_count_nxt;
    logic             r_wrapped, w_wrapped_nxt;

    // Button 0 is clear and never repeats; up/down repeat only when enabled.
    for (genvar g = 0; g < 3; g++) begin : g_btn
        debounced_updown_counter_btn #(
            .TW             (TW),
            .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_RATE    (REPEAT_RATE),
            .CAN_REPEAT     (REPEAT_EN != 0 && g != 0)
        ) u_btn (
            .clock_divider_out (clock_divider_out),
            .reset             (reset),
            .i_btn_n           (bus.btn_n[g]),
            .o_step            (w_step[g])
        );
    end

    always_comb begin
        w_count_nxt   = r_count;
        w_wrapped_nxt = 1'b0;
        if (w_step[0]) begin
            w_count_nxt = '0;
        end else if (w_step[1] && !w_step[2]) begin
            if (r_count == '1) begin
                w_wrapped_nxt = 1'b1;
                if (SATURATE == 0) w_count_nxt = '0;
            end else begin
                w_count_nxt = r_count + 1'b1;
            end
        end else if (w_step[2] && !w_step[1]) begin
            if (r_count == '0) begin
                w_wrapped_nxt = 1'b1;
                if (SATURATE == 0) w_count_nxt = '1;
            end else begin
                w_count_nxt = r_count - 1'b1;
            end
        end
    end

    always_ff @(posedge clock_divider_out or posedge reset) begin
        if (reset) begin
            r_count   <= '0;
            r_wrapped <= 1'b0;
        end else begin
            r_count   <= w_count_nxt;
            r_wrapped <= w_wrapped_nxt;
        end
    end

    assign bus.count     = r_count;
    assign bus.led_n     = ~r_count;
    assign bus.step_up   = w_step[1];
    assign bus.step_down = w_step[2];
    assign bus.wrapped   = r_wrapped;
endmodule

// File: tb/tb_debounced_updown_counter.sv
// Bench for debounced_updown_counter: dut A repeats and wraps, dut B saturates without repeat.
// A behavioural model tracks both every tick; directed tables and sequences cover the corners.
module tb_debounced_updown_counter;
    localparam int DEB = 4, RDLY = 16, RRATE = 4;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0, failures = 0;
    int   n_up[2], n_dn[2], n_wr[2];

    debounced_updown_counter_if #(.WIDTH(8)) ifa ();
    debounced_updown_counter_if #(.WIDTH(8)) ifb ();

    debounced_updown_counter #(.WIDTH(8), .DEBOUNCE_TICKS(DEB), .REPEAT_EN(1), .REPEAT_DELAY(RDLY),
                               .REPEAT_RATE(RRATE), .SATURATE(0))
        dut_a (.clock_divider_out(clk), .reset(reset), .bus(ifa));
    debounced_updown_counter #(.WIDTH(8), .DEBOUNCE_TICKS(DEB), .REPEAT_EN(0), .REPEAT_DELAY(RDLY),
                               .REPEAT_RATE(RRATE), .SATURATE(1))
        dut_b (.clock_divider_out(clk), .reset(reset), .bus(ifb));

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: modes 0 released, 1 press debounce, 2 down, 3 release debounce.
    // While down, run is the hold age; repeats fall at RDLY + k*RRATE.
    int m_mode[2][3], m_run[2][3], m_cnt[2];
    bit m_h0[2][3], m_h1[2][3], m_stp[2][3], m_wr[2];

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_cnt[d] = 0;
            m_wr[d]  = 0;
            for (int b = 0; b < 3; b++) begin
                m_mode[d][b] = 0; m_run[d][b] = 0;
                m_h0[d][b] = 0; m_h1[d][b] = 0; m_stp[d][b] = 0;
            end
        end
    endtask

    task automatic model_tick();
        logic [2:0] bn;
        int nxt;
        bit p, st, rep, sat;
        for (int d = 0; d < 2; d++) begin
            bn  = (d == 0) ? ifa.btn_n : ifb.btn_n;
            rep = (d == 0);
            sat = (d == 1);
            m_wr[d] = 0;
            if (m_stp[d][0]) m_cnt[d] = 0;
            else if (m_stp[d][1] != m_stp[d][2]) begin
                nxt = m_cnt[d] + (m_stp[d][1] ? 1 : -1);
                if (nxt < 0 || nxt > 255) begin
                    m_wr[d] = 1;
                    if (!sat) m_cnt[d] = (nxt + 256) % 256;
                end else m_cnt[d] = nxt;
            end
            for (int b = 0; b < 3; b++) begin
                p  = m_h1[d][b];
                st = 0;
                case (m_mode[d][b])
                    0: if (p) begin m_mode[d][b] = 1; m_run[d][b] = 0; end
                    1: if (!p) m_mode[d][b] = 0;
                       else begin
                           m_run[d][b]++;
                           if (m_run[d][b] == DEB) begin m_mode[d][b] = 2; m_run[d][b] = 0; st = 1; end
                       end
                    2: if (!p) begin m_mode[d][b] = 3; m_run[d][b] = 0; end
                       else if (rep && b != 0) begin
                           m_run[d][b]++;
                           if (m_run[d][b] >= RDLY && (m_run[d][b] - RDLY) % RRATE == 0) st = 1;
                       end
                    3: if (p) begin m_mode[d][b] = 2; m_run[d][b] = 0; end
                       else begin
                           m_run[d][b]++;
                           if (m_run[d][b] == DEB) m_mode[d][b] = 0;
                       end
                    default: ;
                endcase
                m_stp[d][b] = st;
                m_h1[d][b]  = m_h0[d][b];
                m_h0[d][b]  = !bn[b];
            end
        end
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) model_reset();
        else model_tick();
    end

    always @(negedge clk) begin
        if (!reset) begin
            check("cycle_a", {ifa.count, ifa.led_n, ifa.step_up, ifa.step_down, ifa.wrapped},
                  {8'(m_cnt[0]), 8'(255 - m_cnt[0]), m_stp[0][1], m_stp[0][2], m_wr[0]});
            check("cycle_b", {ifb.count, ifb.led_n, ifb.step_up, ifb.step_down, ifb.wrapped},
                  {8'(m_cnt[1]), 8'(255 - m_cnt[1]), m_stp[1][1], m_stp[1][2], m_wr[1]});
            n_up[0] += ifa.step_up; n_dn[0] += ifa.step_down; n_wr[0] += ifa.wrapped;
            n_up[1] += ifb.step_up; n_dn[1] += ifb.step_down; n_wr[1] += ifb.wrapped;
        end
    end

    task automatic set_btn(input int d, input logic [2:0] bn);
        if (d == 0) ifa.btn_n = bn;
        else ifb.btn_n = bn;
    endtask

    task automatic press(input int d, input logic [2:0] bn, input int hold, input int rel);
        #1;
        n_up[d] = 0; n_dn[d] = 0; n_wr[d] = 0;
        set_btn(d, bn);
        repeat (hold) @(negedge clk);
        set_btn(d, 3'b111);
        repeat (rel) @(negedge clk);
        #1;
    endtask

    typedef struct {
        logic [2:0] bn;
        int hold;
        int cnt;
        int up;
        int dn;
        int wr;
    } vec_t;
    vec_t tbl[13];

    initial begin
        tbl[0]  = '{3'b101, 10,  1, 1, 0, 0};  // up
        tbl[1]  = '{3'b101, 100, 2, 1, 0, 0};  // long hold, no repeat
        tbl[2]  = '{3'b101, 3,   2, 0, 0, 0};  // glitch
        tbl[3]  = '{3'b101, 4,   2, 0, 0, 0};  // one tick short of debounce
        tbl[4]  = '{3'b101, 5,   3, 1, 0, 0};  // shortest accepted press
        tbl[5]  = '{3'b011, 10,  2, 0, 1, 0};
        tbl[6]  = '{3'b011, 10,  1, 0, 1, 0};
        tbl[7]  = '{3'b011, 10,  0, 0, 1, 0};
        tbl[8]  = '{3'b011, 10,  0, 0, 1, 1};  // saturate at 0
        tbl[9]  = '{3'b001, 10,  0, 1, 1, 0};  // up+down cancel
        tbl[10] = '{3'b101, 10,  1, 1, 0, 0};
        tbl[11] = '{3'b100, 10,  0, 1, 0, 0};  // clear beats up
        tbl[12] = '{3'b110, 10,  0, 0, 0, 0};  // clear

        ifa.btn_n = 3'b111;
        ifb.btn_n = 3'b111;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_count_a", ifa.count, 8'h00);
        check("rst_led_a", ifa.led_n, 8'hFF);
        check("rst_pulses_a", {ifa.step_up, ifa.step_down, ifa.wrapped}, 3'b000);
        check("rst_count_b", ifb.count, 8'h00);
        reset = 1'b0;

        // Latency and auto-repeat on dut A
        @(negedge clk);
        #1 ifa.btn_n = 3'b101;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 6) check("lat_e6", {ifa.step_up, ifa.count}, {1'b0, 8'd0});
            if (k == 7) check("lat_e7", {ifa.step_up, ifa.count}, {1'b1, 8'd0});
            if (k == 8) check("lat_e8", {ifa.step_up, ifa.count}, {1'b0, 8'd1});
        end
        repeat (39) @(negedge clk);
        check("repeat_40", ifa.count, 8'd7);
        #1 ifa.btn_n = 3'b111;
        repeat (12) @(negedge clk);
        check("repeat_rel", ifa.count, 8'd8);

        // Modulo wrap on dut A
        press(0, 3'b110, 10, 12);
        check("a_clear", ifa.count, 8'h00);
        press(0, 3'b011, 6, 12);
        check("a_down_wrap", {ifa.count, 8'(n_wr[0])}, {8'hFF, 8'd1});
        press(0, 3'b101, 6, 12);
        check("a_up_wrap", {ifa.count, 8'(n_wr[0])}, {8'h00, 8'd1});

        // Table on dut B
        for (int i = 0; i < 13; i++) begin
            press(1, tbl[i].bn, tbl[i].hold, 12);
            check($sformatf("tbl%0d_cnt", i), ifb.count, 8'(tbl[i].cnt));
            check($sformatf("tbl%0d_pulses", i), {8'(n_up[1]), 8'(n_dn[1]), 8'(n_wr[1])},
                  {8'(tbl[i].up), 8'(tbl[i].dn), 8'(tbl[i].wr)});
        end

        // Release bounce gives no second step
        #1;
        n_up[1] = 0;
        ifb.btn_n = 3'b101;
        repeat (10) @(negedge clk);
        ifb.btn_n = 3'b111;
        repeat (2) @(negedge clk);
        ifb.btn_n = 3'b101;
        repeat (10) @(negedge clk);
        ifb.btn_n = 3'b111;
        repeat (12) @(negedge clk);
        #1;
        check("bounce", {ifb.count, 8'(n_up[1])}, {8'd1, 8'd1});

        // Saturate at the top on dut B
        for (int i = 0; i < 254; i++) press(1, 3'b101, 6, 10);
        check("b_top", ifb.count, 8'hFF);
        press(1, 3'b101, 6, 12);
        check("b_sat_up", {ifb.count, 8'(n_up[1]), 8'(n_wr[1])}, {8'hFF, 8'd1, 8'd1});

        // Random stimulus, model checks every tick
        for (int i = 0; i < 150; i++) begin
            ifa.btn_n = {1'($urandom), 1'($urandom), ($urandom_range(0, 7) != 0)};
            ifb.btn_n = {1'($urandom), 1'($urandom), ($urandom_range(0, 7) != 0)};
            repeat ($urandom_range(1, 40)) @(negedge clk);
        end
        ifa.btn_n = 3'b111;
        ifb.btn_n = 3'b111;
        repeat (12) @(negedge clk);

        // Async reset mid-count, button held across reset release
        press(0, 3'b110, 10, 12);
        press(0, 3'b101, 6, 12);
        check("pre_reset", ifa.count, 8'd1);
        @(negedge clk);
        ifa.btn_n = 3'b101;
        #3 reset = 1'b1;
        #1;
        check("async_rst", {ifa.count, ifa.led_n, ifb.count}, {8'h00, 8'hFF, 8'h00});
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (k == 6) check("post_rst_e6", {ifa.step_up, ifa.count}, {1'b0, 8'd0});
            if (k == 7) check("post_rst_e7", {ifa.step_up, ifa.count}, {1'b1, 8'd0});
        end
        ifa.btn_n = 3'b111;
        repeat (12) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
